// File: rtl/gate_resp_checker.sv
// gate_resp_checker: checks the six two-input basic gates (OR, AND, NOR, NAND, XOR, XNOR)
// against samples captured on in_valid, counts mismatches and keeps the first failing vector.
// Latency: vec_count updates on the accept edge, err/fail_* one edge later, done two edges later.
// Backpressure: none. In RUN, in_valid may be held high for one sample per cycle.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 begins a run (honoured in IDLE or DONE only)
//   in_valid/in_a/in_b    stimulus sample strobe and the stimulus pair
//   dut_out[5:0]          observed {xnor, xor, nand, nor, and, or}
//   busy/done/pass        run status (pass = done with no errors)
//   err_count/vec_count   saturating mismatch count / samples accepted this run
//   fail_valid/fail_vec/fail_mask  first failing sample: {a,b} and expected^observed
//
// Optional feature macro: GATE_CHK_COVERAGE_EN
//   When defined, a run also has to see all four {a,b} combinations before it
//   can finish, and pass requires full coverage.

module gate_resp_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic [5:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       vec_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [5:0]       fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]       LAST_CNT = 8'(NUM_VECTORS);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Reference model, packed in the same order as dut_out.
  function automatic logic [5:0] gate_exp(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a & b), ~(a | b), a & b, a | b};
  endfunction

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [7:0]       vec_count_q, vec_count_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic [5:0]       fail_mask_q, fail_mask_d;

  // Compare stage 1: the accepted sample waits here one cycle before its
  // result is folded into the counters.
  logic             s1_vld_q, s1_vld_d;
  logic             s1_a_q, s1_a_d;
  logic             s1_b_q, s1_b_d;
  logic [5:0]       s1_obs_q, s1_obs_d;

  logic             accept;
  logic             run_complete;
  logic [5:0]       s1_mask;
  logic             s1_mis;

`ifdef GATE_CHK_COVERAGE_EN
  logic [3:0]       cov_q, cov_d;
`endif

  assign accept  = (state_q == S_RUN) && in_valid;
  assign s1_mask = gate_exp(s1_a_q, s1_b_q) ^ s1_obs_q;
  assign s1_mis  = s1_vld_q && (s1_mask != 6'd0);

  always_comb begin
    state_d      = state_q;
    err_count_d  = err_count_q;
    vec_count_d  = vec_count_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_mask_d  = fail_mask_q;
    s1_vld_d     = accept;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_obs_d     = s1_obs_q;
    run_complete = 1'b0;
`ifdef GATE_CHK_COVERAGE_EN
    cov_d        = cov_q;
`endif

    if (accept) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_obs_d = dut_out;
    end

    // Apply the result of the sample sitting in stage 1.
    if (s1_mis) begin
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_vec_d   = {s1_a_q, s1_b_q};
        fail_mask_d  = s1_mask;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          err_count_d  = '0;
          vec_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_mask_d  = '0;
          s1_vld_d     = 1'b0;
`ifdef GATE_CHK_COVERAGE_EN
          cov_d        = '0;
`endif
        end
      end
      S_RUN: begin
        if (accept) begin
          vec_count_d = (vec_count_q == 8'hFF) ? 8'hFF : vec_count_q + 8'd1;
`ifdef GATE_CHK_COVERAGE_EN
          cov_d        = cov_q | (4'b0001 << {in_a, in_b});
          run_complete = (vec_count_d >= LAST_CNT) && (cov_d == 4'b1111);
`else
          run_complete = (vec_count_d >= LAST_CNT);
`endif
          if (run_complete) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave only once the last sample's compare has been applied, so the
        // counters are already final in the first cycle done is high.
        if (!s1_vld_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      err_count_q  <= '0;
      vec_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_mask_q  <= '0;
      s1_vld_q     <= 1'b0;
      s1_a_q       <= 1'b0;
      s1_b_q       <= 1'b0;
      s1_obs_q     <= '0;
`ifdef GATE_CHK_COVERAGE_EN
      cov_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      err_count_q  <= err_count_d;
      vec_count_q  <= vec_count_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_mask_q  <= fail_mask_d;
      s1_vld_q     <= s1_vld_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_obs_q     <= s1_obs_d;
`ifdef GATE_CHK_COVERAGE_EN
      cov_q        <= cov_d;
`endif
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err_count  = err_count_q;
  assign vec_count  = vec_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_mask  = fail_mask_q;

`ifdef GATE_CHK_COVERAGE_EN
  assign pass = done && (err_count_q == '0) && (cov_q == 4'b1111);
`else
  assign pass = done && (err_count_q == '0);
`endif

endmodule
